reg_dump_streamer: RTL

//  End-of-test register dump engine; the producer side of the golden-file register check.
//  - Watches architectural register MARKER_REG through a dedicated regfile debug read port.
//  - When that register equals MARKER_VAL, or the watchdog expires, it halts the CPU.
//  - It then streams x0..x31 in order over a valid/ready word stream to the host/log sink.
//  - Sits beside cpu_top; taps the regfile's combinational debug read port.

---
 rtl/reg_dump_pkg.sv | 22 ++
 rtl/reg_dump_streamer_if.sv | 26 ++
 rtl/reg_dump_timer.sv | 39 +++
 rtl/reg_dump_streamer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the end-of-test register dump engine.
// Optional checksum beat is enabled by defining REG_DUMP_CHECKSUM_EN.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    WATCH = 2'd0,
    HALT  = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NUM_REGS     = 32;
  localparam int IDX_W        = 6;
  localparam int LAST_REG_IDX = 31;
  localparam int CSUM_IDX     = 32;

  // Running mod-2^32 checksum of dumped words.
  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Valid/ready word stream carrying the register dump to the host/log sink.
interface reg_dump_streamer_if;

  logic                            dump_valid;
  logic                            dump_ready;
  logic [31:0]                     dump_data;
  logic [reg_dump_pkg::IDX_W-1:0]  dump_idx;
  logic                            dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_idx,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_idx,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/reg_dump_timer.sv
// Saturating watchdog: counts enabled cycles, flags the last watch cycle.
module reg_dump_timer #(
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step while enabled, stick at the ceiling so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/reg_dump_streamer.sv
// Halts the CPU on the end-of-test marker (or watchdog) and streams x0..x31 out.
// Defining REG_DUMP_CHECKSUM_EN appends a sum-of-words beat at index 32.
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int          MARKER_REG     = 11,
  parameter logic [31:0] MARKER_VAL     = 32'h0000_C0DE,
  parameter int          TIMEOUT_CYCLES = 50
) (
  input  logic                clk,
  input  logic                reset,
  output logic [4:0]          dbg_raddr,
  input  logic [31:0]         dbg_rdata,
  output logic                cpu_halt,
  reg_dump_streamer_if.master dump,
  output logic                done,
  output logic                timed_out
);

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(CSUM_IDX);
  logic [31:0] csum_q, csum_d;
`else
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(LAST_REG_IDX);
`endif

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             halt_q, halt_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             wd_en;
  logic             wd_expired;

  assign wd_en = (state_q == WATCH);

  reg_dump_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // FSM next state, debug read address and stream register updates.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    tout_d    = tout_q;
    dbg_raddr = 5'(MARKER_REG);
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      WATCH: begin
        // Marker is checked first so a coincident expiry is not reported as a timeout.
        if (dbg_rdata == MARKER_VAL) begin
          state_d = HALT;
        end else if (wd_expired) begin
          state_d = HALT;
          tout_d  = 1'b1;
        end else begin
          state_d = WATCH;
        end
      end
      HALT: begin
        dbg_raddr = 5'd0;
        data_d    = dbg_rdata;
        idx_d     = '0;
        valid_d   = 1'b1;
        last_d    = 1'b0;
        state_d   = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d    = 32'd0;
`endif
      end
      SEND: begin
        // Prefetch the next register so it is ready the cycle the current beat is taken.
        dbg_raddr = idx_q[4:0] + 5'd1;
        if (valid_q && dump.dump_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            last_d = ((idx_q + IDX_W'(1)) == FINAL_IDX);
`ifdef REG_DUMP_CHECKSUM_EN
            csum_d = csum_add(csum_q, data_q);
            if (idx_q == IDX_W'(LAST_REG_IDX)) begin
              data_d = csum_add(csum_q, data_q);
            end else begin
              data_d = dbg_rdata;
            end
`else
            data_d = dbg_rdata;
`endif
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = WATCH;
      end
    endcase
    halt_d = (state_d != WATCH);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WATCH;
      data_q  <= 32'd0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_last  = last_q;
  assign cpu_halt        = halt_q;
  assign done            = done_q;
  assign timed_out       = tout_q;

endmodule
